// File: rtl/axi_arb_pkg.sv
// Shared encodings and constants for the CPU AXI master arbiter.
package axi_arb_pkg;

    // Read channel FSM: one outstanding read, owned by inst or data side.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // Write channel FSM: data side only, address then beats then response.
    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_ADDR = 3'd1,
        W_WIN  = 3'd2,
        W_DATA = 3'd3,
        W_RESP = 3'd4
    } w_state_t;

    // Which upstream master currently owns the read channel.
    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] AXI_LOCK_DEF  = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEF = 4'b0000;
    localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

endpackage

// File: rtl/axi_read_mux.sv
// Read-side arbiter: grants one of the inst/data masters, registers its AR
// request onto the merged port and routes R beats back to the owner until rlast.
module axi_read_mux
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ID_W-1:0]   i_arid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    input  logic              i_arvalid,
    output logic              i_arready,
    output logic [ID_W-1:0]   i_rid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_rresp,
    output logic              i_rlast,
    output logic              i_rvalid,
    input  logic              i_rready,

    input  logic [ID_W-1:0]   d_arid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic [2:0]        d_arsize,
    input  logic [1:0]        d_arburst,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [ID_W-1:0]   d_rid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,

    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    r_state_t state, state_nxt;
    owner_t   owner;
    owner_t   rr_ptr;
    logic     grant_inst;
    logic     grant_data;
    logic     rd_done;

    assign rd_done = (state == R_DATA) && m_rvalid && m_rready && m_rlast;

    // Pick a winner only in R_IDLE; rr_ptr names the master preferred on a tie.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (reset && (state == R_IDLE)) begin
            if (d_arvalid && (!i_arvalid || (DATA_PRIO != 0) || (rr_ptr == OWNER_DATA))) begin
                grant_data = 1'b1;
            end else if (i_arvalid) begin
                grant_inst = 1'b1;
            end
        end
        i_arready = grant_inst;
        d_arready = grant_data;
    end

    // Read FSM next-state: idle -> address handshake -> data beats until rlast.
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE: if (grant_inst || grant_data) state_nxt = R_ADDR;
            R_ADDR: if (m_arvalid && m_arready)   state_nxt = R_DATA;
            R_DATA: if (rd_done)                  state_nxt = R_IDLE;
            default:                              state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= R_IDLE;
        else        state <= state_nxt;
    end

    // Registered AR request, owner tracking and round-robin pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arvalid <= 1'b0;
            owner     <= OWNER_INST;
            rr_ptr    <= OWNER_INST;
        end else begin
            if (grant_data) begin
                m_arid    <= d_arid;
                m_araddr  <= d_araddr;
                m_arlen   <= d_arlen;
                m_arsize  <= d_arsize;
                m_arburst <= d_arburst;
                m_arvalid <= 1'b1;
                owner     <= OWNER_DATA;
            end else if (grant_inst) begin
                m_arid    <= i_arid;
                m_araddr  <= i_araddr;
                m_arlen   <= i_arlen;
                m_arsize  <= i_arsize;
                m_arburst <= i_arburst;
                m_arvalid <= 1'b1;
                owner     <= OWNER_INST;
            end
            if ((state == R_ADDR) && m_arready) begin
                m_arvalid <= 1'b0;
            end
            if (rd_done) begin
                rr_ptr <= (owner == OWNER_INST) ? OWNER_DATA : OWNER_INST;
            end
        end
    end

    // Route R beats to the owner only; the other side sees an idle, zeroed channel.
    always_comb begin
        i_rid    = '0;
        i_rdata  = '0;
        i_rresp  = RESP_OKAY;
        i_rlast  = 1'b0;
        i_rvalid = 1'b0;
        d_rid    = '0;
        d_rdata  = '0;
        d_rresp  = RESP_OKAY;
        d_rlast  = 1'b0;
        d_rvalid = 1'b0;
        m_rready = 1'b0;
        if (state == R_DATA) begin
            if (owner == OWNER_INST) begin
                i_rid    = m_rid;
                i_rdata  = m_rdata;
                i_rresp  = m_rresp;
                i_rlast  = m_rlast;
                i_rvalid = m_rvalid;
                m_rready = i_rready;
            end else begin
                d_rid    = m_rid;
                d_rdata  = m_rdata;
                d_rresp  = m_rresp;
                d_rlast  = m_rlast;
                d_rvalid = m_rvalid;
                m_rready = d_rready;
            end
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Merges the inst and data AXI masters onto the single CPU AXI master port.
// Reads go through axi_read_mux; the data-only write path is handled here.
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int DATA_PRIO = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ID_W-1:0]     i_arid,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [ID_W-1:0]     i_rid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [1:0]          i_rresp,
    output logic                i_rlast,
    output logic                i_rvalid,
    input  logic                i_rready,

    input  logic [ID_W-1:0]     d_arid,
    input  logic [ADDR_W-1:0]   d_araddr,
    input  logic [7:0]          d_arlen,
    input  logic [2:0]          d_arsize,
    input  logic [1:0]          d_arburst,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [ID_W-1:0]     d_rid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [1:0]          d_rresp,
    output logic                d_rlast,
    output logic                d_rvalid,
    input  logic                d_rready,

    input  logic [ID_W-1:0]     d_awid,
    input  logic [ADDR_W-1:0]   d_awaddr,
    input  logic [7:0]          d_awlen,
    input  logic [2:0]          d_awsize,
    input  logic [1:0]          d_awburst,
    input  logic                d_awvalid,
    output logic                d_awready,
    input  logic [ID_W-1:0]     d_wid,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic                d_wlast,
    input  logic                d_wvalid,
    output logic                d_wready,
    output logic [ID_W-1:0]     d_bid,
    output logic [1:0]          d_bresp,
    output logic                d_bvalid,
    input  logic                d_bready,

    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [1:0]          m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,

    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [1:0]          m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ID_W-1:0]     m_wid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    w_state_t w_state, w_state_nxt;

    assign m_arlock  = AXI_LOCK_DEF;
    assign m_arcache = AXI_CACHE_DEF;
    assign m_arprot  = AXI_PROT_DEF;
    assign m_awlock  = AXI_LOCK_DEF;
    assign m_awcache = AXI_CACHE_DEF;
    assign m_awprot  = AXI_PROT_DEF;

    axi_read_mux #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .DATA_PRIO (DATA_PRIO)
    ) u_read_mux (
        .clk       (clk),
        .reset     (reset),
        .i_arid    (i_arid),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_arsize  (i_arsize),
        .i_arburst (i_arburst),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_rid     (i_rid),
        .i_rdata   (i_rdata),
        .i_rresp   (i_rresp),
        .i_rlast   (i_rlast),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .d_arid    (d_arid),
        .d_araddr  (d_araddr),
        .d_arlen   (d_arlen),
        .d_arsize  (d_arsize),
        .d_arburst (d_arburst),
        .d_arvalid (d_arvalid),
        .d_arready (d_arready),
        .d_rid     (d_rid),
        .d_rdata   (d_rdata),
        .d_rresp   (d_rresp),
        .d_rlast   (d_rlast),
        .d_rvalid  (d_rvalid),
        .d_rready  (d_rready),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    // Upstream readies and B routing depend only on local state and upstream valids.
    always_comb begin
        d_awready = 1'b0;
        d_wready  = 1'b0;
        d_bid     = '0;
        d_bresp   = RESP_OKAY;
        d_bvalid  = 1'b0;
        m_bready  = 1'b0;
        case (w_state)
            W_IDLE: d_awready = reset && d_awvalid;
            W_WIN:  d_wready  = d_wvalid;
            W_RESP: begin
                d_bid    = m_bid;
                d_bresp  = m_bresp;
                d_bvalid = m_bvalid;
                m_bready = d_bready;
            end
            default: ;
        endcase
    end

    // Write FSM next-state: address, then beat-by-beat data, then response.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: if (d_awready)            w_state_nxt = W_ADDR;
            W_ADDR: if (m_awready)            w_state_nxt = W_WIN;
            W_WIN:  if (d_wready)             w_state_nxt = W_DATA;
            W_DATA: if (m_wready)             w_state_nxt = m_wlast ? W_RESP : W_WIN;
            W_RESP: if (m_bvalid && d_bready) w_state_nxt = W_IDLE;
            default:                          w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Registered AW and W payloads presented on the merged port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_awid    <= '0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            m_awsize  <= '0;
            m_awburst <= '0;
            m_awvalid <= 1'b0;
            m_wid     <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_wlast   <= 1'b0;
            m_wvalid  <= 1'b0;
        end else begin
            if (d_awready) begin
                m_awid    <= d_awid;
                m_awaddr  <= d_awaddr;
                m_awlen   <= d_awlen;
                m_awsize  <= d_awsize;
                m_awburst <= d_awburst;
                m_awvalid <= 1'b1;
            end else if ((w_state == W_ADDR) && m_awready) begin
                m_awvalid <= 1'b0;
            end
            if (d_wready) begin
                m_wid    <= d_wid;
                m_wdata  <= d_wdata;
                m_wstrb  <= d_wstrb;
                m_wlast  <= d_wlast;
                m_wvalid <= 1'b1;
            end else if ((w_state == W_DATA) && m_wready) begin
                m_wvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a fixed-priority instance and a
// round-robin instance share all inputs; the slave side is driven by hand.
module tb_axi_master_arbiter;
    import axi_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    logic clk, reset;
    logic [ID_W-1:0] i_arid, d_arid, d_awid, d_wid, m_rid, m_bid;
    logic [ADDR_W-1:0] i_araddr, d_araddr, d_awaddr;
    logic [7:0] i_arlen, d_arlen, d_awlen;
    logic [2:0] i_arsize, d_arsize, d_awsize;
    logic [1:0] i_arburst, d_arburst, d_awburst, m_rresp, m_bresp;
    logic i_arvalid, i_rready, d_arvalid, d_rready, d_awvalid, d_wlast, d_wvalid, d_bready;
    logic [DATA_W-1:0] d_wdata, m_rdata;
    logic [STRB_W-1:0] d_wstrb;
    logic m_arready, m_awready, m_wready, m_rlast, m_rvalid, m_bvalid;

    logic i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid;
    logic d_awready, d_wready, d_bvalid, m_arvalid, m_awvalid, m_wlast, m_wvalid, m_rready, m_bready;
    logic [ID_W-1:0] i_rid, d_rid, d_bid, m_arid, m_awid, m_wid;
    logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata;
    logic [1:0] i_rresp, d_rresp, d_bresp, m_arburst, m_awburst, m_arlock, m_awlock;
    logic [ADDR_W-1:0] m_araddr, m_awaddr;
    logic [7:0] m_arlen, m_awlen;
    logic [2:0] m_arsize, m_awsize, m_arprot, m_awprot;
    logic [3:0] m_arcache, m_awcache;
    logic [STRB_W-1:0] m_wstrb;

    logic rr_i_arready, rr_i_rlast, rr_i_rvalid, rr_d_arready, rr_d_rlast, rr_d_rvalid;
    logic rr_d_awready, rr_d_wready, rr_d_bvalid, rr_m_arvalid, rr_m_awvalid, rr_m_wlast;
    logic rr_m_wvalid, rr_m_rready, rr_m_bready;
    logic [ID_W-1:0] rr_i_rid, rr_d_rid, rr_d_bid, rr_m_arid, rr_m_awid, rr_m_wid;
    logic [DATA_W-1:0] rr_i_rdata, rr_d_rdata, rr_m_wdata;
    logic [1:0] rr_i_rresp, rr_d_rresp, rr_d_bresp, rr_m_arburst, rr_m_awburst, rr_m_arlock, rr_m_awlock;
    logic [ADDR_W-1:0] rr_m_araddr, rr_m_awaddr;
    logic [7:0] rr_m_arlen, rr_m_awlen;
    logic [2:0] rr_m_arsize, rr_m_awsize, rr_m_arprot, rr_m_awprot;
    logic [3:0] rr_m_arcache, rr_m_awcache;
    logic [STRB_W-1:0] rr_m_wstrb;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DATA_PRIO(1)) dut (
        .clk(clk), .reset(reset),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_arid(d_arid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arburst(d_arburst), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rid(d_rid), .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_awid(d_awid), .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
        .d_awburst(d_awburst), .d_awvalid(d_awvalid), .d_awready(d_awready),
        .d_wid(d_wid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_wvalid(d_wvalid), .d_wready(d_wready),
        .d_bid(d_bid), .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    axi_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DATA_PRIO(0)) dut_rr (
        .clk(clk), .reset(reset),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .i_arready(rr_i_arready),
        .i_rid(rr_i_rid), .i_rdata(rr_i_rdata), .i_rresp(rr_i_rresp), .i_rlast(rr_i_rlast),
        .i_rvalid(rr_i_rvalid), .i_rready(i_rready),
        .d_arid(d_arid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arburst(d_arburst), .d_arvalid(d_arvalid), .d_arready(rr_d_arready),
        .d_rid(rr_d_rid), .d_rdata(rr_d_rdata), .d_rresp(rr_d_rresp), .d_rlast(rr_d_rlast),
        .d_rvalid(rr_d_rvalid), .d_rready(d_rready),
        .d_awid(d_awid), .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
        .d_awburst(d_awburst), .d_awvalid(d_awvalid), .d_awready(rr_d_awready),
        .d_wid(d_wid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_wvalid(d_wvalid), .d_wready(rr_d_wready),
        .d_bid(rr_d_bid), .d_bresp(rr_d_bresp), .d_bvalid(rr_d_bvalid), .d_bready(d_bready),
        .m_arid(rr_m_arid), .m_araddr(rr_m_araddr), .m_arlen(rr_m_arlen), .m_arsize(rr_m_arsize),
        .m_arburst(rr_m_arburst), .m_arlock(rr_m_arlock), .m_arcache(rr_m_arcache),
        .m_arprot(rr_m_arprot), .m_arvalid(rr_m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(rr_m_rready),
        .m_awid(rr_m_awid), .m_awaddr(rr_m_awaddr), .m_awlen(rr_m_awlen), .m_awsize(rr_m_awsize),
        .m_awburst(rr_m_awburst), .m_awlock(rr_m_awlock), .m_awcache(rr_m_awcache),
        .m_awprot(rr_m_awprot), .m_awvalid(rr_m_awvalid), .m_awready(m_awready),
        .m_wid(rr_m_wid), .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb), .m_wlast(rr_m_wlast),
        .m_wvalid(rr_m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(rr_m_bready)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // Arbitration vector: inputs, then {i_arready,d_arready,d_awready,rr_i_arready,rr_d_arready}.
    typedef struct {
        logic       rst_val;
        logic       i_arv;
        logic       d_arv;
        logic       d_awv;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset     = v.rst_val;
        i_arvalid = v.i_arv;
        d_arvalid = v.d_arv;
        d_awvalid = v.d_awv;
        #1;
    endtask

    task automatic setInstAr(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [ID_W-1:0] id);
        i_araddr = addr; i_arlen = len; i_arid = id; i_arsize = 3'd2; i_arburst = BURST_INCR;
    endtask

    task automatic setDataAr(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
        d_araddr = addr; d_arlen = 8'd0; d_arid = id; d_arsize = 3'd2; d_arburst = BURST_INCR;
    endtask

    task automatic setRBeat(input logic [DATA_W-1:0] data, input logic last, input logic [ID_W-1:0] id);
        m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rid = id; m_rresp = RESP_OKAY;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b000_00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b100_10};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b010_01};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b010_10};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b001_00};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b011_10};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b000_00};

        reset = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
        d_arid = '0; d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arburst = '0; d_arvalid = 1'b0;
        d_awid = '0; d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_awburst = '0; d_awvalid = 1'b0;
        d_wid = '0; d_wdata = '0; d_wstrb = '0; d_wlast = 1'b0; d_wvalid = 1'b0;
        i_rready = 1'b1; d_rready = 1'b1; d_bready = 1'b1;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;

        // Reset state, with requests already pending upstream.
        #12;
        i_arvalid = 1'b1; d_arvalid = 1'b1; d_awvalid = 1'b1; d_wvalid = 1'b1;
        #1;
        checkOutput("reset_ready_valid",
            {i_arready, d_arready, d_awready, d_wready, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 9'h0);
        checkOutput("reset_payload", {m_araddr, m_awaddr}, 64'h0);
        checkOutput("const_lock_cache_prot", {m_arlock, m_arcache, m_arprot, m_awlock, m_awcache, m_awprot}, 18'h0);
        i_arvalid = 1'b0; d_arvalid = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Combinational grant table, sampled in R_IDLE/W_IDLE and withdrawn before the edge.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("arb_vec%0d", k),
                {i_arready, d_arready, d_awready, rr_i_arready, rr_d_arready}, vecs[k].exp);
            i_arvalid = 1'b0; d_arvalid = 1'b0; d_awvalid = 1'b0; reset = 1'b1;
            #1;
        end
        tick();

        // Inst single read.
        setInstAr(32'hBFC0_0000, 8'd0, 4'h1);
        i_arvalid = 1'b1;
        #1 checkOutput("t2_i_arready", i_arready, 1'b1);
        tick();
        i_arvalid = 1'b0;
        checkOutput("t2_m_ar", {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'hBFC0_0000, 8'd0});
        tick();
        checkOutput("t2_m_arvalid_held", m_arvalid, 1'b1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        checkOutput("t2_m_arvalid_drop", m_arvalid, 1'b0);
        setRBeat(32'h3C08_0000, 1'b1, 4'h1);
        #1 checkOutput("t2_i_r", {i_rvalid, i_rdata, i_rid, d_rvalid, m_rready},
                       {1'b1, 32'h3C08_0000, 4'h1, 1'b0, 1'b1});
        tick();
        m_rvalid = 1'b0;
        #1 checkOutput("t2_i_rvalid_done", i_rvalid, 1'b0);

        // Simultaneous reads, data wins with DATA_PRIO=1.
        tick();
        setInstAr(32'h1FC0_0010, 8'd0, 4'h2);
        setDataAr(32'h8000_0040, 4'h3);
        i_arvalid = 1'b1; d_arvalid = 1'b1;
        #1 checkOutput("t3_grant", {i_arready, d_arready}, 2'b01);
        tick();
        d_arvalid = 1'b0;
        checkOutput("t3_m_araddr_data", m_araddr, 32'h8000_0040);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        setRBeat(32'h1111_1111, 1'b1, 4'h3);
        #1 checkOutput("t3_d_r", {d_rvalid, d_rdata, i_rvalid, i_arready}, {1'b1, 32'h1111_1111, 1'b0, 1'b0});
        tick();
        m_rvalid = 1'b0;
        #1 checkOutput("t3_inst_grant_after_rlast", i_arready, 1'b1);
        tick();
        i_arvalid = 1'b0;
        checkOutput("t3_m_ar_inst", {m_arvalid, m_araddr, m_arid}, {1'b1, 32'h1FC0_0010, 4'h2});
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        setRBeat(32'h2222_2222, 1'b1, 4'h2);
        #1 checkOutput("t3_i_r", {i_rvalid, i_rdata, d_rvalid}, {1'b1, 32'h2222_2222, 1'b0});
        tick();
        m_rvalid = 1'b0;

        // Single-beat write with delayed slave handshakes.
        d_awaddr = 32'h8000_1000; d_awid = 4'h5; d_awlen = 8'd0; d_awsize = 3'd2; d_awburst = BURST_INCR;
        d_awvalid = 1'b1;
        #1 checkOutput("t4_d_awready", d_awready, 1'b1);
        tick();
        d_awvalid = 1'b0;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_wlast = 1'b1; d_wid = 4'h5; d_wvalid = 1'b1;
        #1 checkOutput("t4_m_aw", {m_awvalid, m_awaddr, m_awid, d_wready}, {1'b1, 32'h8000_1000, 4'h5, 1'b0});
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("t4_awvalid_wait%0d", k), m_awvalid, 1'b1);
        end
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        #1 checkOutput("t4_d_wready", {m_awvalid, d_wready}, 2'b01);
        tick();
        d_wvalid = 1'b0;
        checkOutput("t4_m_w", {m_wvalid, m_wdata, m_wstrb, m_wlast}, {1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1});
        tick();
        tick();
        checkOutput("t4_wvalid_held", m_wvalid, 1'b1);
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        #1 checkOutput("t4_b_wait", {m_wvalid, d_bvalid, m_bready}, 3'b001);
        tick();
        m_bvalid = 1'b1; m_bid = 4'h5; m_bresp = RESP_OKAY;
        #1 checkOutput("t4_d_b", {d_bvalid, d_bid, d_bresp}, {1'b1, 4'h5, 2'b00});
        tick();
        m_bvalid = 1'b0;
        d_awvalid = 1'b1;
        #1 checkOutput("t4_back_to_idle", {d_bvalid, d_awready}, 2'b01);
        d_awvalid = 1'b0;

        // Inst burst of four beats; data request arrives at beat 2 and must wait.
        tick();
        setInstAr(32'hBFC0_0100, 8'd3, 4'h1);
        setDataAr(32'h8000_0080, 4'h6);
        i_arvalid = 1'b1;
        tick();
        i_arvalid = 1'b0;
        checkOutput("t5_m_arlen", m_arlen, 8'd3);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            setRBeat(32'hA0 + k, (k == 4), 4'h1);
            if (k == 2) d_arvalid = 1'b1;
            #1 checkOutput($sformatf("t5_beat%0d", k), {i_rvalid, i_rdata, i_rlast, d_rvalid, d_arready},
                           {1'b1, 32'hA0 + k, (k == 4), 1'b0, 1'b0});
            tick();
        end
        m_rvalid = 1'b0;
        #1 checkOutput("t5_d_arready_after_rlast", d_arready, 1'b1);
        tick();
        d_arvalid = 1'b0;
        checkOutput("t5_m_araddr_data", m_araddr, 32'h8000_0080);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        setRBeat(32'h3333_3333, 1'b1, 4'h6);
        #1 checkOutput("t5_d_r", {d_rvalid, d_rdata}, {1'b1, 32'h3333_3333});
        tick();
        m_rvalid = 1'b0;

        // Inst read concurrent with a data write.
        setInstAr(32'hBFC0_0200, 8'd0, 4'h1);
        d_awaddr = 32'h8000_2000; d_awid = 4'h7;
        d_wdata = 32'hCAFE_F00D; d_wid = 4'h7; d_wlast = 1'b1; d_wstrb = 4'h3;
        i_arvalid = 1'b1; d_awvalid = 1'b1; d_wvalid = 1'b1;
        #1 checkOutput("t6_grants", {i_arready, d_awready}, 2'b11);
        tick();
        i_arvalid = 1'b0; d_awvalid = 1'b0;
        m_arready = 1'b1; m_awready = 1'b1;
        tick();
        m_arready = 1'b0; m_awready = 1'b0;
        setRBeat(32'h1234_5678, 1'b1, 4'h1);
        #1 checkOutput("t6_r_and_wready", {i_rvalid, i_rdata, d_rvalid, d_bvalid, d_wready},
                       {1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1});
        tick();
        m_rvalid = 1'b0; d_wvalid = 1'b0;
        checkOutput("t6_m_w", {m_wvalid, m_wdata, m_wstrb}, {1'b1, 32'hCAFE_F00D, 4'h3});
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        m_bvalid = 1'b1; m_bid = 4'h7; m_bresp = 2'b10;
        #1 checkOutput("t6_b", {d_bvalid, d_bid, d_bresp, i_rvalid, d_rvalid}, {1'b1, 4'h7, 2'b10, 1'b0, 1'b0});
        tick();
        m_bvalid = 1'b0;

        // Reset dropped in the middle of an inst burst.
        setInstAr(32'hBFC0_0300, 8'd3, 4'h1);
        i_arvalid = 1'b1;
        tick();
        i_arvalid = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        setRBeat(32'h55, 1'b0, 4'h1);
        #1 checkOutput("t1_burst_active", i_rvalid, 1'b1);
        #1 reset = 1'b0;
        i_arvalid = 1'b1; d_arvalid = 1'b1; d_awvalid = 1'b1;
        #1 checkOutput("t1_midburst_reset",
            {i_arready, d_arready, d_awready, d_wready, i_rvalid, d_rvalid, d_bvalid,
             m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 12'h0);
        i_arvalid = 1'b0; d_arvalid = 1'b0; d_awvalid = 1'b0; m_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("t1_idle_after_release", {m_arvalid, m_awvalid, m_araddr}, 34'h0);

        // Round-robin instance alternates over back-to-back pairs; fixed-priority one keeps data.
        setInstAr(32'h1FC0_0010, 8'd0, 4'h2);
        setDataAr(32'h8000_0040, 4'h3);
        i_arvalid = 1'b1; d_arvalid = 1'b1;
        m_arready = 1'b1;
        setRBeat(32'h7777_7777, 1'b1, 4'h0);
        for (int k = 0; k < 8; k++) begin
            #1 checkOutput($sformatf("t3rr_grant%0d", k),
                           {rr_i_arready, rr_d_arready, i_arready, d_arready},
                           {(k % 2 == 0), (k % 2 == 1), 1'b0, 1'b1});
            tick();
            checkOutput($sformatf("t3rr_addr%0d", k), rr_m_araddr,
                        (k % 2 == 0) ? 32'h1FC0_0010 : 32'h8000_0040);
            tick();
            tick();
        end
        i_arvalid = 1'b0; d_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
